mdio_peripheral: RTL and testbench

//  PHY-side MDIO slave, directly downstream of mdio_controller: consumes MDC/MDIO_OUT/MDIO_OE, returns MDIO_IN.

---
 rtl/mdio_peripheral.sv | 168 ++++++++++++++++
 tb/tb_mdio_peripheral.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_peripheral.sv
// PHY-side Clause-22 MDIO slave. MDC is oversampled on CLK; frames without
// preamble are decoded, writes go to an external 32x16 memory, reads are
// fetched from it and serialized back on MDIO_IN.
module mdio_peripheral #(
  parameter logic [4:0] PHY_ADDR = 5'b00001
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDC,
  input  logic        MDIO_OE,
  input  logic        MDIO_OUT,
  input  logic [15:0] RD_DATA,
  output logic        MDIO_IN,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        MEMORY_WR,
  output logic        MDIO_DONE
);

  localparam int unsigned CNT_W    = 6;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned HDR_LAST = 13;  // count before the 14th header bit
  localparam int unsigned TA_FIRST = 14;
  localparam int unsigned TA_LAST  = 15;
  localparam int unsigned BIT_LAST = 31;
  localparam int unsigned FRAME_N  = 32;

  typedef enum logic [2:0] {
    IDLE, HEADER, WR_BITS, COMMIT, TURNAROUND, RD_BITS, WAIT_IDLE
  } state_t;

  state_t              state_q, state_d;
  logic                mdc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-2:0]   in_sr;
  logic [DATA_W-1:0]   out_sr;

  logic                mdc_rise, mdc_fall;
  logic [13:0]         hdr;
  logic                hdr_ok;
  logic                shift_in, cnt_inc, addr_ld, wdata_ld, rd_ld, rd_shift;
  logic                pulse_wr, pulse_done;

  assign mdc_rise = ~mdc_q & MDC;
  assign mdc_fall = mdc_q & ~MDC;

  // Header as it stands once the current bit is shifted in: ST,OP,PHYAD,REGAD
  assign hdr    = {in_sr[12:0], MDIO_OUT};
  assign hdr_ok = (hdr[13:12] == 2'b01) &&
                  ((hdr[11:10] == 2'b01) || (hdr[11:10] == 2'b10)) &&
                  (hdr[9:5] == PHY_ADDR);

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    shift_in   = 1'b0;
    cnt_inc    = 1'b0;
    addr_ld    = 1'b0;
    wdata_ld   = 1'b0;
    rd_ld      = 1'b0;
    rd_shift   = 1'b0;
    pulse_wr   = 1'b0;
    pulse_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (mdc_rise && MDIO_OE) begin
          shift_in = 1'b1;
          cnt_inc  = 1'b1;
          state_d  = HEADER;
        end
      end
      HEADER: begin
        if (!MDIO_OE) begin
          state_d = IDLE;
        end else if (mdc_rise) begin
          shift_in = 1'b1;
          cnt_inc  = 1'b1;
          if (cnt_q == CNT_W'(HDR_LAST)) begin
            if (hdr_ok) begin
              addr_ld = 1'b1;
              state_d = (hdr[11:10] == 2'b01) ? WR_BITS : TURNAROUND;
            end else begin
              state_d = WAIT_IDLE;
            end
          end
        end
      end
      WR_BITS: begin
        if (!MDIO_OE) begin
          state_d = IDLE;
        end else if (mdc_rise) begin
          shift_in = 1'b1;
          cnt_inc  = 1'b1;
          if (cnt_q == CNT_W'(BIT_LAST)) begin
            wdata_ld = 1'b1;
            state_d  = COMMIT;
          end
        end
      end
      COMMIT: begin
        pulse_wr   = 1'b1;
        pulse_done = 1'b1;
        state_d    = WAIT_IDLE;
      end
      TURNAROUND: begin
        if (mdc_rise) begin
          cnt_inc = 1'b1;
          if (cnt_q == CNT_W'(TA_FIRST)) rd_ld = 1'b1;
          if (cnt_q == CNT_W'(TA_LAST))  state_d = RD_BITS;
        end
      end
      RD_BITS: begin
        if (MDIO_OE) begin
          state_d = WAIT_IDLE;
        end else begin
          if (mdc_fall) rd_shift = 1'b1;
          if (mdc_rise) begin
            cnt_inc = 1'b1;
            if (cnt_q == CNT_W'(BIT_LAST)) begin
              pulse_done = 1'b1;
              state_d    = IDLE;
            end
          end
        end
      end
      WAIT_IDLE: begin
        if (!MDIO_OE || (cnt_q == CNT_W'(FRAME_N))) state_d = IDLE;
        else if (mdc_rise)                          cnt_inc = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: MDC sync, bit counter, shift registers and registered outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mdc_q     <= 1'b0;
      cnt_q     <= '0;
      in_sr     <= '0;
      out_sr    <= '0;
      MDIO_IN   <= 1'b0;
      ADDR      <= '0;
      WR_DATA   <= '0;
      MEMORY_WR <= 1'b0;
      MDIO_DONE <= 1'b0;
    end else begin
      mdc_q <= MDC;
      if (state_d == IDLE) cnt_q <= '0;
      else if (cnt_inc)    cnt_q <= cnt_q + CNT_W'(1);
      if (shift_in) in_sr   <= {in_sr[DATA_W-3:0], MDIO_OUT};
      if (addr_ld)  ADDR    <= hdr[4:0];
      if (wdata_ld) WR_DATA <= {in_sr, MDIO_OUT};
      if (rd_ld)         out_sr <= RD_DATA;
      else if (rd_shift) out_sr <= {out_sr[DATA_W-2:0], 1'b0};
      if (rd_shift)                MDIO_IN <= out_sr[DATA_W-1];
      else if (state_d != RD_BITS) MDIO_IN <= 1'b0;
      MEMORY_WR <= pulse_wr;
      MDIO_DONE <= pulse_done;
    end
  end

endmodule

// File: tb/tb_mdio_peripheral.sv
// Bench for mdio_peripheral: directed vector table, reset-in-flight sequence,
// then random frames scored against a frame-level reference model.
module tb_mdio_peripheral;

  localparam logic [4:0] PHY = 5'd1;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        MDC = 1'b0;
  logic        MDIO_OE = 1'b0;
  logic        MDIO_OUT = 1'b0;
  logic [15:0] RD_DATA;
  logic        MDIO_IN;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA;
  logic        MEMORY_WR;
  logic        MDIO_DONE;

  logic [15:0] env_mem [32];
  logic [15:0] ref_mem [32];
  logic [4:0]  m_addr;
  logic [15:0] m_wdata;

  int wr_cnt = 0, done_cnt = 0, n_checks = 0, n_fail = 0;

  mdio_peripheral #(.PHY_ADDR(PHY)) dut (
    .CLK(CLK), .RESET(RESET), .MDC(MDC), .MDIO_OE(MDIO_OE), .MDIO_OUT(MDIO_OUT),
    .RD_DATA(RD_DATA), .MDIO_IN(MDIO_IN), .ADDR(ADDR), .WR_DATA(WR_DATA),
    .MEMORY_WR(MEMORY_WR), .MDIO_DONE(MDIO_DONE)
  );

  always #5 CLK = ~CLK;

  // External register memory the peripheral talks to
  assign RD_DATA = env_mem[ADDR];
  always @(posedge CLK) if (MEMORY_WR) env_mem[ADDR] <= WR_DATA;

  // Pulse counters
  always @(negedge CLK) begin
    if (MEMORY_WR) wr_cnt++;
    if (MDIO_DONE) done_cnt++;
  end

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    int          e_wr;
    int          e_done;
    logic [4:0]  e_addr;
    logic [15:0] e_wd;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vt [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op,
                                     input logic [4:0] phy, input logic [4:0] rg,
                                     input logic [15:0] d);
    logic [1:0] ta;
    ta = (op == 2'b10) ? 2'b00 : 2'b10;
    return {st, op, phy, rg, ta, d};
  endfunction

  // Drive nbits of a frame as the controller would; capture MDIO_IN at each data-bit rise
  task automatic run_frame(input logic [31:0] f, input int nbits, output logic [15:0] rd,
                           output int dwr, output int ddone);
    int wr0, dn0;
    bit is_rd;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    rd = '0;
    is_rd = (f[29:28] == 2'b10);
    for (int k = 0; k < nbits; k++) begin
      int i;
      i = 31 - k;
      MDC = 1'b0;
      MDIO_OE = !(is_rd && i <= 17);
      MDIO_OUT = MDIO_OE ? f[i] : 1'b0;
      repeat (4) @(negedge CLK);
      if (i <= 15) rd[i] = MDIO_IN;
      MDC = 1'b1;
      repeat (4) @(negedge CLK);
    end
    MDC = 1'b0;
    MDIO_OE = 1'b0;
    MDIO_OUT = 1'b0;
    repeat (16) @(negedge CLK);
    dwr = wr_cnt - wr0;
    ddone = done_cnt - dn0;
  endtask

  task automatic apply(input string tag, input logic [31:0] f, input int nbits,
                       input int e_wr, input int e_done, input logic [4:0] e_addr,
                       input logic [15:0] e_wd, input logic [15:0] e_rd);
    logic [15:0] rd;
    int dw, dd;
    run_frame(f, nbits, rd, dw, dd);
    check({tag, " memory_wr pulses"}, 32'(dw), 32'(e_wr));
    check({tag, " mdio_done pulses"}, 32'(dd), 32'(e_done));
    check({tag, " addr"}, 32'(ADDR), 32'(e_addr));
    check({tag, " wr_data"}, 32'(WR_DATA), 32'(e_wd));
    check({tag, " serial read"}, 32'(rd), 32'(e_rd));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    int dw, dd;

    for (int i = 0; i < 32; i++) begin
      env_mem[i] = 16'($urandom);
      ref_mem[i] = env_mem[i];
    end

    // Reset state
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset mdio_in", 32'(MDIO_IN), 32'd0);
    check("reset addr", 32'(ADDR), 32'd0);
    check("reset wr_data", 32'(WR_DATA), 32'd0);
    check("reset memory_wr", 32'(MEMORY_WR), 32'd0);
    check("reset mdio_done", 32'(MDIO_DONE), 32'd0);

    // Directed vectors: {frame, bits sent, wr pulses, done pulses, addr, wr_data, read data}
    vt[0]  = '{mk(2'b01, 2'b01, PHY,   5'd3, 16'hABCD), 32, 1, 1, 5'd3, 16'hABCD, 16'h0000};
    vt[1]  = '{mk(2'b01, 2'b01, PHY,   5'd5, 16'h1234), 32, 1, 1, 5'd5, 16'h1234, 16'h0000};
    vt[2]  = '{mk(2'b01, 2'b10, PHY,   5'd5, 16'h0000), 32, 0, 1, 5'd5, 16'h1234, 16'h1234};
    vt[3]  = '{mk(2'b01, 2'b01, 5'd2,  5'd9, 16'hFFFF), 32, 0, 0, 5'd5, 16'h1234, 16'h0000};
    vt[4]  = '{mk(2'b00, 2'b01, PHY,   5'd7, 16'h00FF), 32, 0, 0, 5'd5, 16'h1234, 16'h0000};
    vt[5]  = '{mk(2'b01, 2'b11, PHY,   5'd7, 16'h00FF), 32, 0, 0, 5'd5, 16'h1234, 16'h0000};
    vt[6]  = '{mk(2'b01, 2'b01, PHY,   5'd7, 16'h00FF), 32, 1, 1, 5'd7, 16'h00FF, 16'h0000};
    vt[7]  = '{mk(2'b01, 2'b01, PHY,   5'd3, 16'hDEAD), 10, 0, 0, 5'd7, 16'h00FF, 16'h0000};
    vt[8]  = '{mk(2'b01, 2'b10, PHY,   5'd5, 16'h0000), 32, 0, 1, 5'd5, 16'h00FF, 16'h1234};
    vt[9]  = '{mk(2'b01, 2'b01, PHY,   5'd5, 16'hBEEF), 20, 0, 0, 5'd5, 16'h00FF, 16'h0000};
    vt[10] = '{mk(2'b01, 2'b10, PHY,   5'd3, 16'h0000), 32, 0, 1, 5'd3, 16'h00FF, 16'hABCD};
    vt[11] = '{mk(2'b01, 2'b10, 5'd3,  5'd3, 16'h0000), 32, 0, 0, 5'd3, 16'h00FF, 16'h0000};

    for (int v = 0; v < 12; v++)
      apply($sformatf("vec%0d", v), vt[v].frame, vt[v].nbits, vt[v].e_wr, vt[v].e_done,
            vt[v].e_addr, vt[v].e_wd, vt[v].e_rd);
    ref_mem[3] = 16'hABCD;
    ref_mem[5] = 16'h1234;
    ref_mem[7] = 16'h00FF;

    // Reset asserted in the middle of a read
    run_frame(mk(2'b01, 2'b10, PHY, 5'd3, 16'h0000), 24, rd, dw, dd);
    check("midread addr before reset", 32'(ADDR), 32'd3);
    check("midread no done", 32'(dd), 32'd0);
    @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("async reset mdio_in", 32'(MDIO_IN), 32'd0);
    check("async reset addr", 32'(ADDR), 32'd0);
    check("async reset wr_data", 32'(WR_DATA), 32'd0);
    check("async reset memory_wr", 32'(MEMORY_WR), 32'd0);
    check("async reset mdio_done", 32'(MDIO_DONE), 32'd0);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    apply("post-reset write", mk(2'b01, 2'b01, PHY, 5'd1, 16'h5A5A), 32, 1, 1, 5'd1, 16'h5A5A, 16'h0000);
    ref_mem[1] = 16'h5A5A;
    apply("post-reset read", mk(2'b01, 2'b10, PHY, 5'd1, 16'h0000), 32, 0, 1, 5'd1, 16'h5A5A, 16'h5A5A);
    m_addr = 5'd1;
    m_wdata = 16'h5A5A;

    // Random frames against the frame-level model
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  st, op;
      logic [4:0]  phy, rg;
      logic [15:0] d, erd;
      int          nb, ew, ed;
      bit          ok;
      st = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b01;
      case ($urandom_range(0, 9))
        0:          op = 2'b00;
        1:          op = 2'b11;
        2, 3, 4, 5: op = 2'b01;
        default:    op = 2'b10;
      endcase
      phy = ($urandom_range(0, 4) == 0) ? 5'($urandom) : PHY;
      rg  = 5'($urandom);
      d   = 16'($urandom);
      nb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 13)) : 32;
      ok  = (st == 2'b01) && (phy == PHY) && (op == 2'b01 || op == 2'b10) && (nb == 32);
      ew = 0;
      ed = 0;
      erd = '0;
      if (ok) begin
        m_addr = rg;
        ed = 1;
        if (op == 2'b01) begin
          ew = 1;
          m_wdata = d;
          ref_mem[rg] = d;
        end else begin
          erd = ref_mem[rg];
        end
      end
      apply($sformatf("rnd%0d", n), mk(st, op, phy, rg, d), nb, ew, ed, m_addr, m_wdata, erd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
